cam_match_decoder: RTL and testbench

// - Consumer end of the CAM search path: takes the ENTRIES-wide match vector the CAM drives
//   (one bit per entry) and decodes it back into entry indices.
// - Emits one index per accepted transfer, lowest index first, on a valid/ready stream.
// - Sits between the cam core and downstream logic (readback, host serialiser) in the TT design.

---
 rtl/cam_match_decoder_pkg.sv | 15 +
 rtl/cam_match_decoder_if.sv | 23 ++
 rtl/cam_match_decoder_prio_enc.sv | 19 +
 rtl/cam_match_decoder.sv | 80 ++++++++
 tb/tb_cam_match_decoder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/cam_match_decoder_pkg.sv
// Shared CAM sizing, decoder state encoding and a popcount helper.
package cam_pkg;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = $clog2(ENTRIES);

    typedef enum logic {IDLE, EMIT} state_t;

    function automatic logic [IDX_W:0] popcount(input logic [ENTRIES-1:0] v);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < ENTRIES; i++)
            cnt = cnt + (IDX_W+1)'(v[i]);
        return cnt;
    endfunction
endpackage

// File: rtl/cam_match_decoder_if.sv
// Match-vector input stream and index output stream of the decoder.
interface cam_match_decoder_if;
    import cam_pkg::*;

    logic               match_valid;
    logic [ENTRIES-1:0] match_vec;
    logic               match_ready;
    logic               idx_valid;
    logic [IDX_W-1:0]   idx;
    logic               idx_last;
    logic               idx_ready;
    logic               none;
    logic [IDX_W:0]     count;

    modport slave (
        input  match_valid, match_vec, idx_ready,
        output match_ready, idx_valid, idx, idx_last, none, count
    );
    modport master (
        output match_valid, match_vec, idx_ready,
        input  match_ready, idx_valid, idx, idx_last, none, count
    );
endinterface

// File: rtl/cam_match_decoder_prio_enc.sv
// Lowest-set-bit encoder; onehot flags that the found bit is the only one set.
module cam_prio_enc
    import cam_pkg::*;
(
    input  logic [ENTRIES-1:0] vec,
    output logic [IDX_W-1:0]   idx,
    output logic               any,
    output logic               onehot
);
    // Scan high to low so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = ENTRIES-1; i >= 0; i--)
            if (vec[i]) idx = IDX_W'(i);
    end

    assign any    = |vec;
    assign onehot = any && ((vec & (vec - ENTRIES'(1))) == '0);
endmodule

// File: rtl/cam_match_decoder.sv
// Decodes a captured CAM match vector into a stream of entry indices, lowest first.
module cam_match_decoder
    import cam_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    cam_match_decoder_if.slave  bus
);
    state_t             state;
    logic [ENTRIES-1:0] pend;
    logic [ENTRIES-1:0] pend_next;
    logic [ENTRIES-1:0] enc_in;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_any;
    logic               enc_onehot;
    logic               capture;
    logic               xfer;

    assign bus.match_ready = (state == IDLE) && ena;
    assign capture         = bus.match_valid && bus.match_ready;
    assign xfer            = bus.idx_valid && bus.idx_ready;
    assign pend_next       = pend & (pend - ENTRIES'(1));

    // One encoder serves both the first index of a new vector and the
    // index that follows an accepted one.
    assign enc_in = (state == IDLE) ? bus.match_vec : pend_next;

    cam_prio_enc u_enc (
        .vec    (enc_in),
        .idx    (enc_idx),
        .any    (enc_any),
        .onehot (enc_onehot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pend         <= '0;
            bus.idx_valid <= 1'b0;
            bus.idx      <= '0;
            bus.idx_last <= 1'b0;
            bus.none     <= 1'b0;
            bus.count    <= '0;
        end else begin
            bus.none <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        pend      <= bus.match_vec;
                        bus.count <= popcount(bus.match_vec);
                        if (!enc_any) begin
                            bus.none <= 1'b1;
                        end else begin
                            state         <= EMIT;
                            bus.idx_valid <= 1'b1;
                            bus.idx       <= enc_idx;
                            bus.idx_last  <= enc_onehot;
                        end
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        pend <= pend_next;
                        if (bus.idx_last) begin
                            state         <= IDLE;
                            bus.idx_valid <= 1'b0;
                            bus.idx       <= '0;
                            bus.idx_last  <= 1'b0;
                        end else begin
                            bus.idx      <= enc_idx;
                            bus.idx_last <= enc_onehot;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cam_match_decoder.sv
// Directed and randomized bench for cam_match_decoder against a queue-based model.
module tb_cam_match_decoder;
    import cam_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    bit   chk_on = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    cam_match_decoder_if bus();

    cam_match_decoder dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: a captured vector becomes a queue of its set-bit indices in ascending order.
    int q[$];
    int m_count = 0;
    bit m_none = 1'b0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete();
            m_count = 0;
            m_none  = 1'b0;
        end else begin
            m_none = 1'b0;
            if (q.size() > 0) begin
                if (bus.idx_ready) void'(q.pop_front());
            end else if (ena && bus.match_valid) begin
                m_count = 0;
                for (int i = 0; i < ENTRIES; i++)
                    if (bus.match_vec[i]) begin
                        q.push_back(i);
                        m_count++;
                    end
                m_none = (m_count == 0);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("match_ready", int'(bus.match_ready), int'(q.size() == 0 && ena));
            chk("idx_valid",   int'(bus.idx_valid),   int'(q.size() > 0));
            chk("idx",         int'(bus.idx),         (q.size() > 0) ? q[0] : 0);
            chk("idx_last",    int'(bus.idx_last),    int'(q.size() == 1));
            chk("none",        int'(bus.none),        int'(m_none));
            chk("count",       int'(bus.count),       m_count);
        end
    end

    task automatic capture(input logic [ENTRIES-1:0] v);
        @(posedge clk); #1;
        bus.match_valid = 1'b1;
        bus.match_vec   = v;
        @(posedge clk); #1;
        bus.match_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ena = 1'b0;
        bus.match_valid = 1'b0;
        bus.match_vec   = '0;
        bus.idx_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ena = 1'b1;
        #1;
        chk("rst_idx_valid",   int'(bus.idx_valid),   0);
        chk("rst_count",       int'(bus.count),       0);
        chk("rst_none",        int'(bus.none),        0);
        chk("rst_idx",         int'(bus.idx),         0);
        chk("rst_match_ready", int'(bus.match_ready), 1);
        chk_on = 1'b1;

        // empty vector
        capture(16'h0000);
        @(negedge clk);
        chk("empty_none",  int'(bus.none),        1);
        chk("empty_count", int'(bus.count),       0);
        chk("empty_valid", int'(bus.idx_valid),   0);
        chk("empty_ready", int'(bus.match_ready), 1);
        @(negedge clk);
        chk("empty_none_pulse", int'(bus.none), 0);

        // two hits, no backpressure
        bus.idx_ready = 1'b1;
        capture(16'h8001);
        @(negedge clk);
        chk("two_idx0",  int'(bus.idx),      0);
        chk("two_last0", int'(bus.idx_last), 0);
        chk("two_count", int'(bus.count),    2);
        @(negedge clk);
        chk("two_idx1",  int'(bus.idx),      15);
        chk("two_last1", int'(bus.idx_last), 1);
        @(negedge clk);
        chk("two_ready", int'(bus.match_ready), 1);
        chk("two_done",  int'(bus.idx_valid),   0);

        // backpressure
        bus.idx_ready = 1'b0;
        capture(16'h0024);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", int'(bus.idx_valid), 1);
            chk("bp_idx",   int'(bus.idx),       2);
            chk("bp_last",  int'(bus.idx_last),  0);
        end
        #1 bus.idx_ready = 1'b1;
        @(negedge clk);
        chk("bp_idx5",  int'(bus.idx),      5);
        chk("bp_last5", int'(bus.idx_last), 1);
        @(negedge clk);
        chk("bp_done", int'(bus.idx_valid), 0);

        // full match
        capture(16'hFFFF);
        for (int i = 0; i < ENTRIES; i++) begin
            @(negedge clk);
            chk("full_idx",   int'(bus.idx),       i);
            chk("full_last",  int'(bus.idx_last),  int'(i == ENTRIES-1));
            chk("full_count", int'(bus.count),     16);
        end
        @(negedge clk);
        chk("full_done", int'(bus.idx_valid), 0);

        // reset mid-emit
        capture(16'h0111);
        @(negedge clk);
        chk("rme_idx0", int'(bus.idx), 0);
        @(negedge clk);
        chk("rme_idx4", int'(bus.idx), 4);
        #1 bus.idx_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rme_valid", int'(bus.idx_valid), 0);
        chk("rme_count", int'(bus.count),     0);
        @(negedge clk);
        #2 rst = 1'b0;
        bus.idx_ready = 1'b1;
        capture(16'h0002);
        @(negedge clk);
        chk("rme_new_valid", int'(bus.idx_valid), 1);
        chk("rme_new_idx",   int'(bus.idx),       1);
        chk("rme_new_last",  int'(bus.idx_last),  1);
        @(negedge clk);

        // enable gating
        @(posedge clk); #1;
        ena = 1'b0;
        bus.match_valid = 1'b1;
        bus.match_vec   = 16'h0004;
        repeat (2) begin
            @(negedge clk);
            chk("ena_ready", int'(bus.match_ready), 0);
            chk("ena_valid", int'(bus.idx_valid),   0);
        end
        #1 ena = 1'b1;
        @(posedge clk); #1;
        bus.match_valid = 1'b0;
        @(negedge clk);
        chk("ena_cap_valid", int'(bus.idx_valid), 1);
        chk("ena_cap_idx",   int'(bus.idx),       2);
        chk("ena_cap_last",  int'(bus.idx_last),  1);

        // randomized traffic
        repeat (3000) begin
            @(posedge clk); #1;
            ena             = ($urandom_range(0, 7) != 0);
            bus.match_valid = ($urandom_range(0, 2) != 0);
            bus.idx_ready   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0:       bus.match_vec = '0;
                1:       bus.match_vec = ENTRIES'(1) << $urandom_range(0, ENTRIES-1);
                2:       bus.match_vec = '1;
                default: bus.match_vec = ENTRIES'($urandom);
            endcase
            if ($urandom_range(0, 249) == 0) begin
                #3 rst = 1'b1;
                #3 rst = 1'b0;
            end
        end

        @(posedge clk); #1;
        bus.match_valid = 1'b0;
        bus.idx_ready   = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
